// File: rtl/apb_hash_block_fifo_if.sv
// rtl/apb_hash_block_fifo_if.sv - APB register interface with a block FIFO feeding a hash core
module apb_hash_block_fifo_if #(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 32,
  parameter int BlockWidth  = 512,
  parameter int DigestWidth = 256,
  parameter int Depth       = 2,
  parameter int DataBytes   = DataWidth / 8
) (
  input  logic                   pclk_i,
  input  logic                   preset_ni,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic [DataWidth-1:0]   pwdata_i,
  input  logic [DataBytes-1:0]   pstrb_i,
  output logic [DataWidth-1:0]   prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  output logic [BlockWidth-1:0]  block_o,
  output logic                   block_last_o,
  output logic                   block_valid_o,
  input  logic                   block_ready_i,
  input  logic                   idle_i,
  input  logic [DigestWidth-1:0] digest_i,
  input  logic                   digest_valid_i,
  output logic                   reset_hash_o,
  output logic                   irq_o
);

  localparam int NumWords = BlockWidth / DataWidth;
  localparam int DigWords = (DigestWidth + DataWidth - 1) / DataWidth;
  localparam int DigPadW  = DigWords * DataWidth;
  localparam int ByteSh   = $clog2(DataBytes);
  localparam int PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW     = $clog2(Depth + 1);
  localparam int WIdxW    = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int DIdxW    = (DigWords > 1) ? $clog2(DigWords) : 1;

  // APB response registers
  logic                   pready_q, pslverr_q;
  logic [DataWidth-1:0]   prdata_q;

  // Register state
  logic [DataWidth-1:0]   stage_q [NumWords];
  logic [BlockWidth-1:0]  stage_flat;
  logic                   irq_en_q, irq_en_d;
  logic                   dv_q, dv_d;
  logic                   irq_q;
  logic                   reset_hash_q;
  logic [DigestWidth-1:0] digest_q;
  logic [DigPadW-1:0]     digest_pad;

  // Block FIFO
  logic [BlockWidth-1:0]  mem_q [Depth];
  logic [Depth-1:0]       last_q;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   full, empty, pop;

  // Decode
  logic [11:0]            offset;
  logic                   access;
  logic                   sel_ctrl, sel_status, sel_stage, sel_dig, any_sel;
  logic [WIdxW-1:0]       stage_idx;
  logic [DIdxW-1:0]       dig_idx;
  logic                   push_blocked, err, wr_ok;
  logic                   ctrl_wr_ok, do_push, do_rst, dv_clr, stage_wr;
  logic [DataWidth-1:0]   rdata;
  logic                   unused_addr;

  assign offset      = paddr_i[11:0];
  assign unused_addr = ^paddr_i[AddrWidth-1:12];
  // The first access cycle is the one where pready is still low; side effects commit at its edge.
  assign access      = psel_i & penable_i & ~pready_q;

  assign full          = (count_q == CntW'(Depth));
  assign empty         = (count_q == '0);
  assign block_valid_o = ~empty;
  assign block_o       = mem_q[rd_ptr_q];
  assign block_last_o  = last_q[rd_ptr_q];
  assign pop           = block_valid_o & block_ready_i;
  assign digest_pad    = DigPadW'(digest_q);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address decode and error classification
  always_comb begin
    sel_ctrl   = (offset == 12'h000);
    sel_status = (offset == 12'(DataBytes));
    sel_stage  = (offset >= 12'h100) && (offset < 12'(256 + NumWords * DataBytes)) &&
                 (offset[ByteSh-1:0] == '0);
    sel_dig    = (offset >= 12'h200) && (offset < 12'(512 + DigWords * DataBytes)) &&
                 (offset[ByteSh-1:0] == '0);
    any_sel    = sel_ctrl | sel_status | sel_stage | sel_dig;
    stage_idx  = WIdxW'((offset - 12'h100) >> ByteSh);
    dig_idx    = DIdxW'((offset - 12'h200) >> ByteSh);
    // A push into a full FIFO is accepted only when the head leaves at the same edge.
    push_blocked = access & pwrite_i & sel_ctrl & pstrb_i[0] & pwdata_i[0] & ~pwdata_i[1] &
                   full & ~block_ready_i;
    err        = access & (~any_sel | (pwrite_i & sel_dig) | push_blocked);
    wr_ok      = access & pwrite_i & ~err;
    ctrl_wr_ok = wr_ok & sel_ctrl & pstrb_i[0];
    do_rst     = ctrl_wr_ok & pwdata_i[1];
    do_push    = ctrl_wr_ok & pwdata_i[0] & ~pwdata_i[1];
    dv_clr     = wr_ok & sel_status & pstrb_i[0] & pwdata_i[3];
    stage_wr   = wr_ok & sel_stage;
  end

  // Read data mux
  always_comb begin
    rdata = '0;
    if (sel_ctrl) begin
      rdata[2] = irq_en_q;
    end else if (sel_status) begin
      rdata[0]    = idle_i;
      rdata[1]    = full;
      rdata[2]    = empty;
      rdata[3]    = dv_q;
      rdata[15:8] = 8'(count_q);
    end else if (sel_stage) begin
      rdata = stage_q[stage_idx];
    end else if (sel_dig) begin
      rdata = digest_pad[int'(dig_idx) * DataWidth +: DataWidth];
    end
  end

  // Flatten staging words into a block, word k at the k-th slice
  always_comb begin
    stage_flat = '0;
    for (int k = 0; k < NumWords; k++) begin
      stage_flat[k * DataWidth +: DataWidth] = stage_q[k];
    end
  end

  // Next values of IRQ_EN and DV; a new digest beats a W1C or RESET in the same cycle
  always_comb begin
    irq_en_d = ctrl_wr_ok ? pwdata_i[2] : irq_en_q;
    dv_d     = dv_q;
    if (dv_clr || do_rst) dv_d = 1'b0;
    if (digest_valid_i)   dv_d = 1'b1;
  end

  // APB response: one wait state, registered data and error
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= access;
      pslverr_q <= err;
      prdata_q  <= (access && !pwrite_i && !err) ? rdata : '0;
    end
  end

  // Byte-strobed staging buffer; kept across PUSH and RESET
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      for (int k = 0; k < NumWords; k++) stage_q[k] <= '0;
    end else if (stage_wr) begin
      for (int b = 0; b < DataBytes; b++) begin
        if (pstrb_i[b]) stage_q[stage_idx][8 * b +: 8] <= pwdata_i[8 * b +: 8];
      end
    end
  end

  // Control, digest capture, interrupt and core reset pulse
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      irq_en_q     <= 1'b0;
      dv_q         <= 1'b0;
      irq_q        <= 1'b0;
      reset_hash_q <= 1'b0;
      digest_q     <= '0;
    end else begin
      irq_en_q     <= irq_en_d;
      dv_q         <= dv_d;
      irq_q        <= irq_en_d & dv_d;
      reset_hash_q <= do_rst;
      if (digest_valid_i) digest_q <= digest_i;
    end
  end

  // Block FIFO; RESET flushes pointers and count at the write edge
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      for (int d = 0; d < Depth; d++) mem_q[d] <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (do_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q]  <= stage_flat;
        last_q[wr_ptr_q] <= pwdata_i[3];
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !pop)      count_q <= count_q + 1'b1;
      else if (!do_push && pop) count_q <= count_q - 1'b1;
    end
  end

  assign prdata_o     = prdata_q;
  assign pready_o     = pready_q;
  assign pslverr_o    = pslverr_q;
  assign reset_hash_o = reset_hash_q;
  assign irq_o        = irq_q;

endmodule

// File: doc/apb_hash_block_fifo_if.md
Name: apb_hash_block_fifo_if

Overview:
- APB completer for the hash cores; next generation of the single-block register interface.
- Stages message words in a write buffer, then commits them into a parametrised-depth block FIFO.
- The FIFO drains to the hash core over a valid/ready handshake, so software can queue blocks while the core computes.
- Captures the digest into a sticky register and raises a maskable interrupt.

Parameters:
DataWidth, 32, APB data width (32 or 64)
AddrWidth, 32, APB address width; only bits [11:0] decoded
BlockWidth, 512, hash block width, multiple of DataWidth
DigestWidth, 256, digest width; zero-padded up to a multiple of DataWidth
Depth, 2, block FIFO depth (>=1)
DataBytes, DataWidth/8, derived, strobe width and word address step

Ports:
pclk_i  in  1  clock
preset_ni  in  1  reset
psel_i  in  1  APB select
penable_i  in  1  APB access phase
pwrite_i  in  1  write/read
paddr_i  in  AddrWidth  address
pwdata_i  in  DataWidth  write data
pstrb_i  in  DataBytes  byte strobes
prdata_o  out  DataWidth  read data
pready_o  out  1  ready
pslverr_o  out  1  error
block_o  out  BlockWidth  FIFO head block; word k at bits [k*DataWidth +: DataWidth]
block_last_o  out  1  head block flagged final
block_valid_o  out  1  FIFO non-empty
block_ready_i  in  1  core accepts head block
idle_i  in  1  core idle
digest_i  in  DigestWidth  digest
digest_valid_i  in  1  digest valid pulse
reset_hash_o  out  1  one-cycle core reset
irq_o  out  1  digest-ready interrupt

Behaviour:
- Reset is asynchronous, active-low on preset_ni; clock is pclk_i. All state and outputs reset to 0: FIFO empty, staging, digest, flags, prdata, pslverr, pready, reset_hash_o, irq_o.
- APB timing: every transfer takes exactly one wait state.
  - First access cycle (psel&penable, pready=0): decode, side effects committed at that clock edge.
  - Second cycle: pready=1 with registered prdata/pslverr.
  - pready is never high outside access. Setup phase has no effect.
- Address map (offset = paddr[11:0]):
  - 0x000 CTRL (W; reads return irq_en in bit2, else 0):
    - bit0 PUSH (pulse): commit staging to FIFO tail.
    - bit1 RESET (pulse).
    - bit2 IRQ_EN (RW).
    - bit3 LAST: stored with the pushed block.
  - 0x000+DataBytes STATUS: bit0 idle_i, bit1 full, bit2 empty, bit3 DV (sticky; W1C), bits[15:8] FIFO count.
  - 0x100+k*DataBytes, k<BlockWidth/DataWidth: staging word k, RW, byte-strobed.
  - 0x200+k*DataBytes, k<ceil(DigestWidth/DataWidth): digest word k, RO.
- Any other offset, any write to the digest region, or a PUSH while full: pslverr=1 and no state change. Reads of an erroring address return 0.
- CTRL and STATUS writes act only if pstrb[0]=1.
- Staging is not cleared by PUSH, so unchanged words may be reused.
- FIFO:
  - Push and pop (block_valid_o & block_ready_i) may occur in the same cycle; count is unchanged.
  - Pointers wrap modulo Depth.
  - block_o/block_last_o are stable while valid and not accepted.
  - Pop on empty is impossible, since valid=0.
- Digest: on digest_valid_i, digest_i is latched and DV is set.
  - If digest_valid_i and a DV W1C occur in the same cycle, set wins.
  - irq_o = IRQ_EN & DV, registered.
- RESET pulse:
  - reset_hash_o=1 the cycle after the write.
  - FIFO flushed and DV cleared at the same edge.
  - Staging and IRQ_EN are kept.
  - If PUSH and RESET are written together, RESET wins and no block is queued.
- paddr[AddrWidth-1:12] is ignored.

Test Plan:
- Write staging words 0..15 = 0x1000_0000+k, read back word 5 -> prdata 0x1000_0005, pready high on the 2nd access cycle only, pslverr=0.
- block_ready_i=0; PUSH twice (Depth=2) -> STATUS count=2, full=1; third PUSH -> pslverr=1, count stays 2.
- Raise block_ready_i with a concurrent PUSH in the same cycle -> count unchanged; block_o word 0 = 0x1000_0000; block_last_o follows the LAST bit written.
- Pulse digest_valid_i with digest_i word0=0xDEADBEEF, IRQ_EN=1 -> irq_o=1 next cycle; read 0x200 -> 0xDEADBEEF; W1C DV -> irq_o=0.
- Write CTRL=0x3 (PUSH+RESET) with 1 queued block -> reset_hash_o single-cycle pulse, FIFO empty, no block queued.
- Read 0x300 and write 0x204 -> pslverr=1, prdata=0, no state change; assert preset_ni low mid-transfer -> all outputs 0 immediately.
